uart_frame_responder: RTL and testbench

Kernel-side return path for the host UART link. It accepts a completed multi-byte frame from the receive side (done pulse plus frame word), captures it, and serialises it back to the host as 8N1 UART bytes, least-significant byte first. It has its own baud counter and shift register, so its output drives the host-bound TX pin directly. It is the kernel-to-host counterpart of the host-to-kernel source/sink pair.

---
 rtl/uart_frame_responder_if.sv | 22 ++
 rtl/uart_frame_responder.sv | 175 +++++++++++++++++
 tb/tb_uart_frame_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_responder_if.sv
// Frame handshake and UART return-line signals for uart_frame_responder.
// The master side presents completed frames; the slave side transmits them.
interface uart_frame_responder_if #(
    parameter int BYTES = 8
);
    logic               iFDONE;
    logic [BYTES*8-1:0] iFDATA;
    logic               oTX;
    logic               oBUSY;
    logic               oDONE;
    logic               oDROP;

    modport master (
        output iFDONE, iFDATA,
        input  oTX, oBUSY, oDONE, oDROP
    );

    modport slave (
        input  iFDONE, iFDATA,
        output oTX, oBUSY, oDONE, oDROP
    );
endinterface

// File: rtl/uart_frame_responder.sv
// Captures a received frame and sends it back to the host as 8N1 bytes, LSB byte first.
// Define UART_RESP_CHKSUM_EN to append an XOR checksum byte after the frame.
module uart_frame_responder #(
    parameter int SCYCLE   = 50000000,
    parameter int BAUDRATE = 115200,
    parameter int BYTES    = 8,
    parameter int STOPBITS = 1
) (
    input logic iCLOCK,
    input logic iRESET,
    uart_frame_responder_if.slave bus
);
    localparam int CLKS_PER_BIT = SCYCLE / BAUDRATE;
`ifdef UART_RESP_CHKSUM_EN
    localparam int NBYTES = BYTES + 1;
`else
    localparam int NBYTES = BYTES;
`endif
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIDX_W = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t             state_q, state_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               drop_q, drop_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [BIDX_W-1:0]  byte_q, byte_d;
    logic [BYTES*8-1:0] frame_q, frame_d;
    logic [7:0]         cur_byte;
    logic               baud_last, last_byte, last_stop;

`ifdef UART_RESP_CHKSUM_EN
    logic [7:0] chk_q, chk_d;
    logic [7:0] fdata_xor;

    always_comb begin
        fdata_xor = '0;
        for (int k = 0; k < BYTES; k++) fdata_xor = fdata_xor ^ bus.iFDATA[k*8 +: 8];
    end
`endif

    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < BYTES; k++)
            if (byte_q == BIDX_W'(k)) cur_byte = frame_q[k*8 +: 8];
`ifdef UART_RESP_CHKSUM_EN
        if (byte_q == BIDX_W'(BYTES)) cur_byte = chk_q;
`endif
    end

    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_byte = (byte_q == BIDX_W'(NBYTES - 1));
    // bit_q doubles as the stop-bit counter while in STOP
    assign last_stop = (bit_q == 3'(STOPBITS - 1));

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        drop_d  = bus.iFDONE && (state_q != S_IDLE);
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
`ifdef UART_RESP_CHKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.iFDONE) begin
                    frame_d = bus.iFDATA;
`ifdef UART_RESP_CHKSUM_EN
                    chk_d   = fdata_xor;
`endif
                    byte_d  = '0;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (last_stop) begin
                        bit_d = '0;
                        if (last_byte) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            tx_d    = 1'b1;
                        end else begin
                            byte_d  = byte_q + BIDX_W'(1);
                            state_d = S_START;
                            tx_d    = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            frame_q <= '0;
`ifdef UART_RESP_CHKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            frame_q <= frame_d;
`ifdef UART_RESP_CHKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign bus.oTX   = tx_q;
    assign bus.oBUSY = busy_q;
    assign bus.oDONE = done_q;
    assign bus.oDROP = drop_q;
endmodule

// File: tb/tb_uart_frame_responder.sv
// Directed bench: default-rate instance for full 434-cycle timing, plus fast
// instances (16 clocks/bit, 1 and 2 stop bits) for overlap, reset and stop-bit cases.
module tb_uart_frame_responder;
`ifdef UART_RESP_CHKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic        clk = 1'b0;
    logic        rst [3];
    logic        fd [3];
    logic [63:0] fdat [3];
    logic        tx_w [3];
    logic        busy_w [3];
    logic        done_w [3];
    logic        drop_w [3];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    uart_frame_responder_if #(.BYTES(8)) if0 ();
    uart_frame_responder_if #(.BYTES(8)) if1 ();
    uart_frame_responder_if #(.BYTES(8)) if2 ();

    uart_frame_responder #(.SCYCLE(50000000), .BAUDRATE(115200), .BYTES(8), .STOPBITS(1))
        u_def (.iCLOCK(clk), .iRESET(rst[0]), .bus(if0));
    uart_frame_responder #(.SCYCLE(1600), .BAUDRATE(100), .BYTES(8), .STOPBITS(1))
        u_fast (.iCLOCK(clk), .iRESET(rst[1]), .bus(if1));
    uart_frame_responder #(.SCYCLE(1600), .BAUDRATE(100), .BYTES(8), .STOPBITS(2))
        u_sb2 (.iCLOCK(clk), .iRESET(rst[2]), .bus(if2));

    assign if0.iFDONE = fd[0];
    assign if1.iFDONE = fd[1];
    assign if2.iFDONE = fd[2];
    assign if0.iFDATA = fdat[0];
    assign if1.iFDATA = fdat[1];
    assign if2.iFDATA = fdat[2];
    assign tx_w[0] = if0.oTX;   assign busy_w[0] = if0.oBUSY;
    assign done_w[0] = if0.oDONE; assign drop_w[0] = if0.oDROP;
    assign tx_w[1] = if1.oTX;   assign busy_w[1] = if1.oBUSY;
    assign done_w[1] = if1.oDONE; assign drop_w[1] = if1.oDROP;
    assign tx_w[2] = if2.oTX;   assign busy_w[2] = if2.oBUSY;
    assign done_w[2] = if2.oDONE; assign drop_w[2] = if2.oDROP;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called right after the capture edge; returns at the first IDLE cycle.
    // Every cycle of every cell is compared with the expected line level.
    task automatic recv(input int s, input int cpb, input int sb, input logic [71:0] exp_v,
                        input int inj_at, input string tag, output int n);
        int   dones;
        int   drops;
        int   first_drop;
        int   len;
        logic err;
        logic exp_bit;
        logic [7:0] got;
        n = 1;
        dones = 0;
        drops = 0;
        first_drop = -1;
        for (int b = 0; b < NB; b++) begin
            got = '0;
            err = 1'b0;
            for (int c = 0; c < 10; c++) begin
                len = (c == 9) ? sb * cpb : cpb;
                exp_bit = (c == 0) ? 1'b0 : (c == 9) ? 1'b1 : exp_v[b*8 + c - 1];
                for (int t = 0; t < len; t++) begin
                    if (tx_w[s] !== exp_bit || busy_w[s] !== 1'b1) err = 1'b1;
                    if (c >= 1 && c <= 8 && t == 0) got[c-1] = tx_w[s];
                    if (done_w[s] === 1'b1) dones++;
                    if (drop_w[s] === 1'b1) begin
                        drops++;
                        if (first_drop < 0) first_drop = n;
                    end
                    fd[s] = (n == inj_at);
                    if (n == inj_at) fdat[s] = ~fdat[s];
                    tick();
                    n++;
                end
            end
            chk($sformatf("%s byte%0d value", tag, b), 64'(got), 64'(exp_v[b*8 +: 8]));
            chk($sformatf("%s byte%0d cell timing", tag, b), 64'(err), 64'(0));
        end
        fd[s] = 1'b0;
        chk({tag, " no early done"}, 64'(dones), 64'(0));
        chk({tag, " drop count"}, 64'(drops), (inj_at > 0) ? 64'(1) : 64'(0));
        if (inj_at > 0) chk({tag, " drop cycle"}, 64'(first_drop), 64'(inj_at + 1));
        chk({tag, " done pulse"}, 64'(done_w[s]), 64'(1));
        chk({tag, " busy after"}, 64'(busy_w[s]), 64'(0));
        chk({tag, " tx idle"}, 64'(tx_w[s]), 64'(1));
    endtask

    task automatic start_frame(input int s, input logic [63:0] d, input string tag);
        fdat[s] = d;
        fd[s] = 1'b1;
        tick();
        fd[s] = 1'b0;
        chk({tag, " start bit"}, 64'(tx_w[s]), 64'(0));
        chk({tag, " busy rise"}, 64'(busy_w[s]), 64'(1));
    endtask

    task automatic quiet(input int s, input int cycles, input string tag);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (tx_w[s] !== 1'b1 || busy_w[s] !== 1'b0 || done_w[s] !== 1'b0 || drop_w[s] !== 1'b0)
                bad = 1'b1;
        end
        chk({tag, " quiet line"}, 64'(bad), 64'(0));
    endtask

    initial begin
        int n;
        for (int s = 0; s < 3; s++) begin
            rst[s] = 1'b1;
            fd[s] = 1'b0;
            fdat[s] = '0;
        end
        tick(); tick(); tick();
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset tx%0d", s), 64'(tx_w[s]), 64'(1));
            chk($sformatf("reset busy%0d", s), 64'(busy_w[s]), 64'(0));
            chk($sformatf("reset done%0d", s), 64'(done_w[s]), 64'(0));
            chk($sformatf("reset drop%0d", s), 64'(drop_w[s]), 64'(0));
            rst[s] = 1'b0;
        end
        tick();

        // Full-rate frame: 434 clocks per bit
        start_frame(0, 64'hB1B0_AFAE_ADAC_ABAA, "t1");
        recv(0, 434, 1, {8'h00, 64'hB1B0_AFAE_ADAC_ABAA}, 0, "t1", n);
        chk("t1 done latency", 64'(n), (NB == 9) ? 64'(39061) : 64'(34721));
        tick();
        chk("t1 done single", 64'(done_w[0]), 64'(0));

        // Back-to-back, second frame issued in the done cycle
        start_frame(1, 64'hB1B0_AFAE_ADAC_ABAA, "t2a");
        recv(1, 16, 1, {8'h00, 64'hB1B0_AFAE_ADAC_ABAA}, 0, "t2a", n);
        start_frame(1, 64'hB1B0_AFAE_ADAC_ABAB, "t2b");
        recv(1, 16, 1, {8'h01, 64'hB1B0_AFAE_ADAC_ABAB}, 0, "t2b", n);
        chk("t2b length", 64'(n), 64'(1 + NB * 160));
        quiet(1, 20, "t2");

        // Overlapping frame is dropped; data bus changes are ignored
        start_frame(1, 64'h8040_2010_0804_0201, "t3");
        recv(1, 16, 1, {8'hFF, 64'h8040_2010_0804_0201}, 1000, "t3", n);
        quiet(1, 80, "t3 no second");

        // Reset during byte 3 DATA
        start_frame(1, 64'h1122_3344_5566_7788, "t4");
        for (int i = 0; i < 499; i++) tick();
        chk("t4 mid data busy", 64'(busy_w[1]), 64'(1));
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        chk("t4 reset tx", 64'(tx_w[1]), 64'(1));
        chk("t4 reset busy", 64'(busy_w[1]), 64'(0));
        quiet(1, 40, "t4 after reset");
        start_frame(1, 64'h1122_3344_5566_7788, "t4b");
        recv(1, 16, 1, {8'h88, 64'h1122_3344_5566_7788}, 0, "t4b", n);

        // Two stop bits
        start_frame(2, 64'h0000_0000_0000_00FF, "t5");
        recv(2, 16, 2, {8'hFF, 64'h0000_0000_0000_00FF}, 0, "t5", n);
        chk("t5 length", 64'(n), 64'(1 + NB * 176));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
